// File: rtl/par_chk_serial.sv
// Serial UART RX parity checker: accumulates parity bit-by-bit, assembles the
// data word, flags parity errors and keeps a saturating error count.
module par_chk_serial #(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int MIN_DATA_WIDTH = 5,
  parameter int CNT_WIDTH      = 8,
  localparam int LEN_W         = $clog2(MAX_DATA_WIDTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LEN_W-1:0]          data_len,
  input  logic                      par_en,
  input  logic [1:0]                par_mode,
  input  logic                      bit_valid,
  input  logic                      sampled_bit,
  input  logic                      err_cnt_clr,
  output logic [MAX_DATA_WIDTH-1:0] P_DATA,
  output logic                      par_err,
  output logic                      chk_done,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state;
  logic             acc;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic             par_en_q;
  logic [1:0]       mode_q;
  logic             par_mis;
  logic             err_inc;

  // Out-of-range lengths fall back to the widest frame.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l < LEN_W'(MIN_DATA_WIDTH) || l > LEN_W'(MAX_DATA_WIDTH))
      return LEN_W'(MAX_DATA_WIDTH);
    return l;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    if (&c)
      return c;
    return c + CNT_WIDTH'(1);
  endfunction

  function automatic logic exp_parity(input logic a, input logic [1:0] mode);
    case (mode)
      2'b00:   return a;
      2'b01:   return ~a;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign par_mis = (sampled_bit != exp_parity(acc, mode_q));
  assign err_inc = (state == PARITY) && bit_valid && !start && par_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= 1'b0;
      cnt      <= '0;
      len_q    <= '0;
      par_en_q <= 1'b0;
      mode_q   <= 2'b00;
      P_DATA   <= '0;
      par_err  <= 1'b0;
      chk_done <= 1'b0;
      busy     <= 1'b0;
      err_cnt  <= '0;
    end else begin
      chk_done <= 1'b0;

      if (err_cnt_clr)
        err_cnt <= err_inc ? CNT_WIDTH'(1) : '0;
      else if (err_inc)
        err_cnt <= sat_inc(err_cnt);

      // A start always wins, aborting any frame in flight silently.
      if (start) begin
        len_q    <= clamp_len(data_len);
        par_en_q <= par_en;
        mode_q   <= par_mode;
        acc      <= 1'b0;
        cnt      <= '0;
        P_DATA   <= '0;
        par_err  <= 1'b0;
        state    <= DATA;
        busy     <= 1'b1;
      end else begin
        case (state)
          DATA: begin
            if (bit_valid) begin
              P_DATA[cnt] <= sampled_bit;
              acc         <= acc ^ sampled_bit;
              cnt         <= cnt + LEN_W'(1);
              if (cnt == len_q - LEN_W'(1)) begin
                if (par_en_q) begin
                  state <= PARITY;
                end else begin
                  par_err  <= 1'b0;
                  chk_done <= 1'b1;
                  state    <= IDLE;
                  busy     <= 1'b0;
                end
              end
            end
          end
          PARITY: begin
            if (bit_valid) begin
              par_err  <= par_mis;
              chk_done <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_par_chk_serial.sv
// Directed bench for par_chk_serial: hand-computed frames covering all parity
// modes, aborts, length clamping, counter saturation/clear and reset.
module tb_par_chk_serial;

  localparam int MAXW  = 9;
  localparam int CNTW  = 8;
  localparam int LEN_W = $clog2(MAXW + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] data_len;
  logic             par_en;
  logic [1:0]       par_mode;
  logic             bit_valid;
  logic             sampled_bit;
  logic             err_cnt_clr;
  logic [MAXW-1:0]  P_DATA;
  logic             par_err;
  logic             chk_done;
  logic             busy;
  logic [CNTW-1:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  par_chk_serial #(.MAX_DATA_WIDTH(MAXW), .MIN_DATA_WIDTH(5), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst(rst), .start(start), .data_len(data_len), .par_en(par_en),
    .par_mode(par_mode), .bit_valid(bit_valid), .sampled_bit(sampled_bit),
    .err_cnt_clr(err_cnt_clr), .P_DATA(P_DATA), .par_err(par_err),
    .chk_done(chk_done), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (chk_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_start(input int len, input logic pen, input logic [1:0] mode);
    @(negedge clk);
    start = 1'b1; data_len = LEN_W'(len); par_en = pen; par_mode = mode;
    @(negedge clk);
    start = 1'b0; data_len = '0; par_en = 1'b0; par_mode = 2'b00;
  endtask

  task automatic send_bit(input logic b, input logic clr);
    bit_valid = 1'b1; sampled_bit = b; err_cnt_clr = clr;
    @(negedge clk);
    bit_valid = 1'b0; sampled_bit = 1'b0; err_cnt_clr = 1'b0;
  endtask

  task automatic send_data(input int n, input logic [15:0] d);
    for (int i = 0; i < n; i++) send_bit(d[i], 1'b0);
  endtask

  task automatic send_frame(input int len, input logic [15:0] d, input logic pen,
                            input logic [1:0] mode, input logic pbit);
    do_start(len, pen, mode);
    send_data(len, d);
    if (pen) send_bit(pbit, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; data_len = '0; par_en = 1'b0; par_mode = 2'b00;
    bit_valid = 1'b0; sampled_bit = 1'b0; err_cnt_clr = 1'b0;
    idle(3);
    rst = 1'b0;
    checks++;
    if ({P_DATA, par_err, chk_done, busy, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got P_DATA=%h par_err=%b chk_done=%b busy=%b err_cnt=%0d, need all 0",
               P_DATA, par_err, chk_done, busy, err_cnt);
    end
  endtask

  task automatic test_even;
    send_frame(8, 16'h00A5, 1'b1, 2'b00, 1'b0);
    checks++;
    if ({chk_done, par_err, P_DATA, err_cnt} !== {1'b1, 1'b0, 9'h0A5, 8'd0}) begin
      errors++;
      $display("FAIL even_ok: got done=%b perr=%b data=%h cnt=%0d, need 1 0 0a5 0",
               chk_done, par_err, P_DATA, err_cnt);
    end
    @(negedge clk);
    checks++;
    if (chk_done !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width: got %b need 0", chk_done);
    end
  endtask

  task automatic test_even_odd_err;
    send_frame(8, 16'h00A5, 1'b1, 2'b00, 1'b1);
    checks++;
    if ({chk_done, par_err, err_cnt} !== {1'b1, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL even_bad: got done=%b perr=%b cnt=%0d, need 1 1 1", chk_done, par_err, err_cnt);
    end
    idle(2);
    checks++;
    if (par_err !== 1'b1) begin
      errors++; $display("FAIL par_err_hold: got %b need 1", par_err);
    end
    send_frame(8, 16'h00A5, 1'b1, 2'b01, 1'b1);
    checks++;
    if ({chk_done, par_err, P_DATA, err_cnt} !== {1'b1, 1'b0, 9'h0A5, 8'd1}) begin
      errors++;
      $display("FAIL odd_ok: got done=%b perr=%b data=%h cnt=%0d, need 1 0 0a5 1",
               chk_done, par_err, P_DATA, err_cnt);
    end
  endtask

  task automatic test_mark_space;
    send_frame(7, 16'h0055, 1'b1, 2'b10, 1'b0);
    checks++;
    if ({par_err, P_DATA, err_cnt} !== {1'b1, 9'h055, 8'd2}) begin
      errors++;
      $display("FAIL mark_bad: got perr=%b data=%h cnt=%0d, need 1 055 2", par_err, P_DATA, err_cnt);
    end
    send_frame(7, 16'h0055, 1'b1, 2'b11, 1'b0);
    checks++;
    if ({chk_done, par_err, err_cnt} !== {1'b1, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL space_ok: got done=%b perr=%b cnt=%0d, need 1 0 2", chk_done, par_err, err_cnt);
    end
  endtask

  task automatic test_no_parity;
    int d0;
    do_start(5, 1'b0, 2'b00);
    send_data(4, 16'h001F);
    checks++;
    if ({chk_done, busy} !== 2'b01) begin
      errors++; $display("FAIL nopar_early: got done=%b busy=%b need 0 1", chk_done, busy);
    end
    send_bit(1'b1, 1'b0);
    checks++;
    if ({chk_done, par_err, P_DATA, busy} !== {1'b1, 1'b0, 9'h01F, 1'b0}) begin
      errors++;
      $display("FAIL nopar_done: got done=%b perr=%b data=%h busy=%b, need 1 0 01f 0",
               chk_done, par_err, P_DATA, busy);
    end
    idle(1);
    d0 = done_cnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    idle(1);
    checks++;
    if ({P_DATA, busy} !== {9'h01F, 1'b0} || done_cnt !== d0) begin
      errors++;
      $display("FAIL idle_bits_ignored: got data=%h busy=%b dones=%0d, need 01f 0 %0d",
               P_DATA, busy, done_cnt, d0);
    end
  endtask

  task automatic test_abort_bounds;
    int d0;
    idle(1);
    d0 = done_cnt;
    do_start(9, 1'b1, 2'b00);
    send_data(3, 16'h0007);
    send_frame(9, 16'h01FF, 1'b1, 2'b00, 1'b1);
    idle(1);
    checks++;
    if ({P_DATA, par_err} !== {9'h1FF, 1'b0} || done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL abort_restart: got data=%h perr=%b dones=%0d, need 1ff 0 %0d",
               P_DATA, par_err, done_cnt, d0 + 1);
    end
    // start with a coincident bit_valid: that bit must be discarded
    @(negedge clk);
    start = 1'b1; data_len = LEN_W'(3); par_en = 1'b0; bit_valid = 1'b1; sampled_bit = 1'b1;
    @(negedge clk);
    start = 1'b0; data_len = '0; bit_valid = 1'b0; sampled_bit = 1'b0;
    send_data(8, 16'h0000);
    checks++;
    if ({chk_done, busy, P_DATA} !== {1'b0, 1'b1, 9'h000}) begin
      errors++;
      $display("FAIL len3_as_9: got done=%b busy=%b data=%h after 8 bits, need 0 1 000",
               chk_done, busy, P_DATA);
    end
    send_bit(1'b1, 1'b0);
    checks++;
    if ({chk_done, P_DATA} !== {1'b1, 9'h100}) begin
      errors++; $display("FAIL len3_done: got done=%b data=%h, need 1 100", chk_done, P_DATA);
    end
  endtask

  task automatic test_counter;
    @(negedge clk);
    err_cnt_clr = 1'b1;
    @(negedge clk);
    err_cnt_clr = 1'b0;
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++; $display("FAIL cnt_clear: got %0d need 0", err_cnt);
    end
    for (int i = 0; i < 255; i++) send_frame(5, 16'h0000, 1'b1, 2'b10, 1'b0);
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++; $display("FAIL cnt_255: got %0d need 255", err_cnt);
    end
    send_frame(5, 16'h0000, 1'b1, 2'b10, 1'b0);
    checks++;
    if ({err_cnt, par_err} !== {8'd255, 1'b1}) begin
      errors++; $display("FAIL cnt_saturate: got cnt=%0d perr=%b need 255 1", err_cnt, par_err);
    end
    do_start(5, 1'b1, 2'b10);
    send_data(5, 16'h0000);
    send_bit(1'b0, 1'b1);
    checks++;
    if ({err_cnt, par_err} !== {8'd1, 1'b1}) begin
      errors++; $display("FAIL cnt_clr_and_inc: got cnt=%0d perr=%b need 1 1", err_cnt, par_err);
    end
  endtask

  task automatic test_reset_midframe;
    do_start(9, 1'b1, 2'b01);
    send_data(3, 16'h0007);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({P_DATA, par_err, chk_done, busy, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_midframe: got data=%h perr=%b done=%b busy=%b cnt=%0d, need all 0",
               P_DATA, par_err, chk_done, busy, err_cnt);
    end
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    checks++;
    if ({P_DATA, busy, chk_done} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: got data=%h busy=%b done=%b, need 0 0 0", P_DATA, busy, chk_done);
    end
  endtask

  initial begin
    test_reset;
    test_even;
    test_even_odd_err;
    test_mark_space;
    test_no_parity;
    test_abort_bounds;
    test_counter;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/par_chk_serial.md
Name: par_chk_serial

Overview:
Parametrised successor to the UART RX parity checker. It accumulates parity serially as data bits arrive from the sampler, so no parallel word is needed first. It supports runtime frame length and five parity modes (none/even/odd/mark/space). It also assembles the received word and keeps a saturating parity-error counter. It sits between the RX data sampler and the RX FSM, and its outputs feed the deserializer and the status registers.

Parameters:
MAX_DATA_WIDTH, 9, largest supported data bits per frame (legal 5..16).
MIN_DATA_WIDTH, 5, smallest supported data bits per frame.
CNT_WIDTH, 8, width of the parity-error counter.
LEN_W, $clog2(MAX_DATA_WIDTH+1), width of data_len (derived, not overridden).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  frame start pulse; latches config and arms the checker.
data_len  in  LEN_W  data bits in this frame; sampled on start.
par_en  in  1  1 = frame carries a parity bit; sampled on start.
par_mode  in  2  00 even, 01 odd, 10 mark, 11 space; sampled on start.
bit_valid  in  1  qualifies sampled_bit for one cycle.
sampled_bit  in  1  serial bit from sampler, data LSB first, then parity.
err_cnt_clr  in  1  clears err_cnt.
P_DATA  out  MAX_DATA_WIDTH  assembled data, LSB-aligned, upper bits zero.
par_err  out  1  parity result of the last completed frame (level).
chk_done  out  1  one-cycle pulse: frame complete; P_DATA and par_err valid.
busy  out  1  high in the DATA and PARITY states.
err_cnt  out  CNT_WIDTH  saturating count of parity errors.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; P_DATA, par_err, chk_done, busy and err_cnt all 0; accumulator, bit counter and latched config all 0.
- Config latch: on start, latch data_len, par_en and par_mode.
  - data_len outside [MIN_DATA_WIDTH, MAX_DATA_WIDTH] is latched as MAX_DATA_WIDTH.
  - Inputs are ignored between starts.
- Start handling: start clears acc, the bit counter, P_DATA and par_err, then goes to DATA.
  - Accepted in any state; a start mid-frame aborts that frame with no chk_done and no count change.
  - If start and bit_valid coincide, start wins and the bit is discarded.
- DATA state, on each bit_valid:
  - P_DATA[cnt] <= sampled_bit; acc <= acc ^ sampled_bit; cnt++.
  - On the bit with cnt = len-1: go to PARITY if par_en=1.
  - If par_en=0: chk_done=1 next cycle, par_err=0, go to IDLE.
- PARITY state, on bit_valid: expected bit = acc (even), ~acc (odd), 1 (mark), 0 (space).
  - par_err <= (sampled_bit != expected); chk_done=1 next cycle; go to IDLE.
- Latency: chk_done and par_err are registered and appear the cycle after the final bit_valid edge.
  - par_err holds until the next start or reset.
- bit_valid in IDLE is ignored.
- busy = (state==DATA || state==PARITY).
- err_cnt: increments in the cycle par_err is set to 1, and saturates at all ones.
  - err_cnt_clr alone sets it to 0.
  - err_cnt_clr together with an increment gives 1.
- No combinational path from input to output; all outputs are registered.

Test Plan:
1. 8 data bits, even parity: start (len=8, par_en=1, mode=00), bits 0xA5 LSB first, parity bit 0 -> P_DATA=0x0A5, par_err=0, chk_done pulses one cycle after the parity bit, err_cnt=0.
2. Same frame with parity bit 1, then odd mode 0xA5 with parity 1 -> first frame par_err=1 and err_cnt=1; second frame par_err=0 and err_cnt stays 1.
3. Mark/space with len=7, data 0x55: mark with parity 0 -> par_err=1; space with parity 0 -> par_err=0.
4. par_en=0, len=5, data 0x1F -> chk_done right after the 5th bit, P_DATA=0x01F, par_err=0; any extra bit_valid is ignored.
5. Abort and boundaries: start after 3 bits of a 9-bit frame, then send a full 9-bit frame 0x1FF with even parity 1 -> only one chk_done, P_DATA=0x1FF, par_err=0. Also data_len=3 is treated as 9.
6. Counter: force 255 errors -> err_cnt=255 and a 256th error keeps 255. err_cnt_clr in the same cycle as an error -> err_cnt=1. rst mid-frame -> all outputs 0 and state IDLE.
